muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the register-file read ports: consumes the two read-bus operands in the execute stage.
- Holds the architectural HI and LO registers and reads them back to the writeback mux (MFHI/MFLO).
- Exports busy so the hazard logic can stall any MFHI/MFLO or new mul/div op issued while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and at least 4.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; sampled only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- busa  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- busb  in  WIDTH  rt operand: multiplier or divisor.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse in the cycle after hi/lo receive a mul/div result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: rst=1 at an edge gives state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. This overrides any operation in progress; the aborted result is discarded.
- States: IDLE, RUN, FIX. busy is decoded from state and is not separately registered.
- IDLE with start=1 and op in 0..3 (edge E0):
  - Latch the signed flag, sign(a), sign(b), |busa| and |busb|. Unsigned ops use the raw values.
  - Clear the 2*WIDTH accumulator and the counter, then go to RUN.
- RUN:
  - One iteration per edge; the counter increments.
  - Multiply: shift-add, one multiplier bit per iteration, LSB first.
  - Divide: restoring radix-2, one quotient bit per iteration, MSB first. The remainder is kept in WIDTH+1 bits.
  - When counter == WIDTH-1 the next edge (E32) goes to FIX.
- FIX (edge E33):
  - Signed multiply: the 64-bit product is negated if sign(a) != sign(b). hi = upper word, lo = lower word.
  - Signed divide: the quotient is negated if sign(a) != sign(b); the remainder takes sign(a). lo = quotient, hi = remainder.
  - Next state IDLE, done=1 in the following cycle.
- Latency with WIDTH=32:
  - busy is high for exactly 33 cycles after E0.
  - hi, lo and done are visible 33 cycles after E0.
  - done is low at all other times.
- MTHI/MTLO: in IDLE with start=1, hi (or lo) <= busa at the next edge. busy and done stay 0, and the other register is unchanged.
- start while busy: ignored. No queueing, and hi/lo are not disturbed.
- op 6/7: ignored entirely.
- hi/lo hold their values through RUN; they change only at FIX, MTHI/MTLO, or reset.
- Divide by zero (deterministic, no trap):
  - DIVU: lo = all ones, hi = busa.
  - DIV: hi = busa; lo = 1 if busa is negative, else all ones.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No exception.
- Back-to-back ops: start may be asserted in the same cycle done=1, because state is already IDLE.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the full product combinationally.
  - hi/lo are written at E0+1, done=1 in the following cycle, and busy is never asserted.
  - DIV/DIVU keep the iterative path.
- Undefined: all four ops use the 33-cycle iterative path above.

Decomposition:
- Shared definitions header (muldiv_defs): op codes, state encodings, default WIDTH/CNT_W. It is also included by the decoder and hazard unit.
- One natural sub-module, muldiv_absneg: WIDTH-bit conditional two's-complement negate. It is instantiated for operand abs and for result sign-fix on both halves.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses 33 cycles after start; busy high 33 cycles.
- MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULDIV_FAST_MULT_EN the same values appear with done one cycle after start and busy=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5. DIV -5 / 0 -> lo=1, hi=0xFFFFFFFB.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle with lo unchanged and done=0. MTLO while busy -> ignored, and the final lo is the mul/div result.
- rst asserted at iteration 10 of a DIV -> next cycle hi=lo=0, busy=0, done=0; no done pulse ever follows. A new MULTU 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default sizes.
// Also pulled in by the decoder and hazard unit so op encodings stay in one place.
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage issue/result bundle between the datapath and the mul/div unit.
// Signal prefixes are from the unit's point of view (i_ into it, o_ out of it).
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();
    logic             i_start;
    md_op_t           i_op;
    logic [WIDTH-1:0] i_busa;
    logic [WIDTH-1:0] i_busb;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_op, i_busa, i_busb,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_start, i_op, i_busa, i_busb,
        output o_hi, o_lo, o_busy, o_done
    );
endinterface

// File: rtl/muldiv_unit_absneg.sv
// Conditional two's-complement negate; i_cin lets two instances chain into a 2*WIDTH negate.
// Latency: combinational. Backpressure: none.
module muldiv_unit_absneg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + WIDTH'(i_cin)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: shift-add multiply, restoring divide, sign fix in a final cycle.
// Latency: 33 cycles for mul/div (1 for MULT/MULTU when MULDIV_FAST_MULT_EN); MTHI/MTLO 1 cycle.
// Backpressure: none; busy tells the hazard unit to stall, start while busy is dropped.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_unit_if.slave  bus
);
    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic               w_neg_hi;
    logic               w_hi_cin;
    logic [WIDTH-1:0]   w_fix_hi_in;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_signed = op_is_signed(bus.i_op);
    assign w_sa     = w_signed & bus.i_busa[WIDTH-1];
    assign w_sb     = w_signed & bus.i_busb[WIDTH-1];

    muldiv_unit_absneg #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg(w_sa), .i_cin(1'b1), .i_val(bus.i_busa), .o_val(w_abs_a));
    muldiv_unit_absneg #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg(w_sb), .i_cin(1'b1), .i_val(bus.i_busb), .o_val(w_abs_b));

    // Multiply: add the multiplicand into the upper half, then shift the whole accumulator right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};

    // Divide: quotient bits collect in r_acc's lower half, dividend bits stream out of r_a's MSB.
    assign w_rem_sh  = {r_rem, r_a[WIDTH-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_qbit    = ~w_diff[WIDTH+1];

    // Product negate spans both halves: the upper word only gets the +1 when the lower word is zero.
    assign w_neg_hi    = r_is_div ? r_sa : (r_sa ^ r_sb);
    assign w_hi_cin    = r_is_div | (r_acc[WIDTH-1:0] == '0);
    assign w_fix_hi_in = r_is_div ? r_rem : r_acc[2*WIDTH-1:WIDTH];

    muldiv_unit_absneg #(.WIDTH(WIDTH)) u_fix_lo (
        .i_neg(r_sa ^ r_sb), .i_cin(1'b1), .i_val(r_acc[WIDTH-1:0]), .o_val(w_fix_lo));
    muldiv_unit_absneg #(.WIDTH(WIDTH)) u_fix_hi (
        .i_neg(w_neg_hi), .i_cin(w_hi_cin), .i_val(w_fix_hi_in), .o_val(w_fix_hi));

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{w_sa}}, bus.i_busa} * {{WIDTH{w_sb}}, bus.i_busb};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        case (bus.i_op)
                            OP_MTHI: r_hi <= bus.i_busa;
                            OP_MTLO: r_lo <= bus.i_busa;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
`ifdef MULDIV_FAST_MULT_EN
                                if (!op_is_div(bus.i_op)) begin
                                    r_hi   <= w_prod[2*WIDTH-1:WIDTH];
                                    r_lo   <= w_prod[WIDTH-1:0];
                                    r_done <= 1'b1;
                                end else
`endif
                                begin
                                    r_is_div <= op_is_div(bus.i_op);
                                    r_sa     <= w_sa;
                                    r_sb     <= w_sb;
                                    r_a      <= w_abs_a;
                                    r_b      <= w_abs_b;
                                    r_acc    <= '0;
                                    r_rem    <= '0;
                                    r_cnt    <= '0;
                                    r_state  <= ST_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_a              <= r_a << 1;
                        r_rem            <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_qbit};
                    end else begin
                        r_b   <= r_b >> 1;
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
    assign bus.o_busy = (r_state != ST_IDLE);
    assign bus.o_done = r_done;

endmodule
